// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op encodings, FSM states and
// the mode encoding used by the iterative multiply/divide datapath.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_REM = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MD_MUL = 2'd0,
    MD_DIV = 2'd1,
    MD_REM = 2'd2
  } md_mode_e;

  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic md_mode_e op_to_mode(input logic [2:0] op);
    md_mode_e m;
    case (op)
      OP_MUL:  m = MD_MUL;
      OP_DIV:  m = MD_DIV;
      default: m = MD_REM;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative 1-bit-per-cycle datapath: shift-add multiply and restoring divide.
// done_o pulses during the final iteration cycle with the result presented combinationally.
module seq_alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  md_mode_e         mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             dz_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // acc: MUL accumulator / DIV partial remainder
  // b:   MUL shifted multiplicand / DIV divisor
  // c:   MUL shifted multiplier / DIV dividend shifting out, quotient shifting in
  logic             busy_q, busy_d;
  md_mode_e         mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;

  assign rem_sh   = {acc_q, c_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, b_q};
  assign rem_ge   = ~rem_diff[WIDTH];

  always_comb begin
    busy_d   = busy_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    c_d      = c_q;
    done_o   = 1'b0;
    result_o = '0;
    if (start_i) begin
      busy_d = 1'b1;
      mode_d = mode_i;
      cnt_d  = '0;
      acc_d  = '0;
      b_d    = b_i;
      c_d    = a_i;
    end else if (busy_q) begin
      if (mode_q == MD_MUL) begin
        acc_d = c_q[0] ? (acc_q + b_q) : acc_q;
        b_d   = b_q << 1;
        c_d   = c_q >> 1;
      end else begin
        // A zero divisor always "fits", yielding all-ones quotient and remainder = dividend.
        acc_d = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        c_d   = {c_q[WIDTH-2:0], rem_ge};
      end
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        done_o = 1'b1;
        busy_d = 1'b0;
      end
    end
    result_o = (mode_q == MD_DIV) ? c_d : acc_d;
  end

  assign dz_o = (mode_q != MD_MUL) && (b_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      mode_q <= MD_MUL;
      cnt_q  <= '0;
      acc_q  <= '0;
      b_q    <= '0;
      c_q    <= '0;
    end else begin
      busy_q <= busy_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      b_q    <= b_d;
      c_q    <= c_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU top: handshake FSM, single-cycle ops and result/flag registers.
// MUL/DIV/REM are delegated to seq_alu_muldiv and take WIDTH iteration cycles.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             zero,
  output logic             carry,
  output logic             dz
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;
  logic             md_dz;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cy;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign dz        = dz_q;

  assign accept   = in_valid && in_ready;
  assign md_start = accept && is_iter_op(op);

  seq_alu_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start_i (md_start),
    .mode_i  (op_to_mode(op)),
    .a_i     (in1),
    .b_i     (in2),
    .done_o  (md_done),
    .result_o(md_result),
    .dz_o    (md_dz)
  );

  // Extra top bit of the difference is the borrow, i.e. in1 < in2.
  assign sum = {1'b0, in1} + {1'b0, in2};
  assign dif = {1'b0, in1} - {1'b0, in2};

  always_comb begin
    alu_res = '0;
    alu_cy  = 1'b0;
    case (op)
      OP_ADD: begin alu_res = sum[WIDTH-1:0]; alu_cy = sum[WIDTH]; end
      OP_SUB: begin alu_res = dif[WIDTH-1:0]; alu_cy = dif[WIDTH]; end
      OP_AND: alu_res = in1 & in2;
      OP_OR:  alu_res = in1 | in2;
      OP_XOR: alu_res = in1 ^ in2;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_iter_op(op)) begin
            state_d = ITER;
          end else begin
            state_d = DONE;
            out_d   = alu_res;
            zero_d  = (alu_res == '0);
            carry_d = alu_cy;
            dz_d    = 1'b0;
          end
        end
      end
      ITER: begin
        if (md_done) begin
          state_d = DONE;
          out_d   = md_result;
          zero_d  = (md_result == '0);
          carry_d = 1'b0;
          dz_d    = md_dz;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      dz_q    <= dz_d;
    end
  end

endmodule
